// File: rtl/burst_arb_pkg.sv
// Shared types for the two-requester burst arbiter.
// Build option: define BURST_ARB_FIXED_PRIO_EN for fixed priority (A wins ties).
package burst_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_t;

    localparam int addr_msb   = 19;
    localparam int data_width = 16;

    // Everything a requester drives towards the backend besides access.
    typedef struct packed {
        logic [addr_msb-1:0]   addr;
        logic [data_width-1:0] data;
        logic                  wr_en;
        logic [1:0]            bytesel;
    } req_cmd_t;

    function automatic req_t other_req(input req_t r);
        return (r == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/burst_arb_picker.sv
// Combinational winner selection for an IDLE arbitration cycle.
// Build option: BURST_ARB_FIXED_PRIO_EN makes A win every tie; otherwise round robin.
module burst_arb_picker
    import burst_arb_pkg::*;
(
    input  logic a_access,
    input  logic b_access,
    input  req_t last_grant,
    output logic pick_valid,
    output req_t pick
);

`ifdef BURST_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        pick_valid = a_access | b_access;
        pick       = a_access ? REQ_A : REQ_B;
    end
`else
    always_comb begin
        pick_valid = a_access | b_access;
        // On a tie the requester that did not hold the previous grant wins.
        if (a_access && b_access) begin
            pick = other_req(last_grant);
        end else begin
            pick = a_access ? REQ_A : REQ_B;
        end
    end
`endif

endmodule

// File: rtl/burst_arbiter.sv
// Two-way memory port arbiter that locks its grant for a whole burst counted in acks.
// Build option: BURST_ARB_FIXED_PRIO_EN selects fixed A-first priority in the picker.
module burst_arbiter
    import burst_arb_pkg::*;
#(
    parameter int burst_len = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [addr_msb-1:0]   a_addr,
    input  logic [data_width-1:0] a_data_out,
    output logic [data_width-1:0] a_data_in,
    input  logic                  a_access,
    output logic                  a_ack,
    input  logic                  a_wr_en,
    input  logic [1:0]            a_bytesel,
    input  logic                  a_burst,

    input  logic [addr_msb-1:0]   b_addr,
    input  logic [data_width-1:0] b_data_out,
    output logic [data_width-1:0] b_data_in,
    input  logic                  b_access,
    output logic                  b_ack,
    input  logic                  b_wr_en,
    input  logic [1:0]            b_bytesel,
    input  logic                  b_burst,

    output logic [addr_msb-1:0]   q_addr,
    output logic [data_width-1:0] q_data_out,
    input  logic [data_width-1:0] q_data_in,
    output logic                  q_access,
    input  logic                  q_ack,
    output logic                  q_wr_en,
    output logic [1:0]            q_bytesel
);

    localparam int cnt_w = $clog2(burst_len);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(burst_len - 1);

    arb_state_t        state_q, state_d;
    logic [cnt_w-1:0]  cnt_q, cnt_d;
    logic              burst_q, burst_d;
    req_t              last_grant_q, last_grant_d;

    logic              pick_valid;
    req_t              pick;
    logic              release_now;
    req_cmd_t          a_cmd, b_cmd, sel_cmd;

    burst_arb_picker u_picker (
        .a_access   (a_access),
        .b_access   (b_access),
        .last_grant (last_grant_q),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    assign a_cmd = '{addr: a_addr, data: a_data_out, wr_en: a_wr_en, bytesel: a_bytesel};
    assign b_cmd = '{addr: b_addr, data: b_data_out, wr_en: b_wr_en, bytesel: b_bytesel};

    // Read data is broadcast; the ack alone tells a requester the word is theirs.
    assign a_data_in = q_data_in;
    assign b_data_in = q_data_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            burst_q      <= 1'b0;
            last_grant_q <= REQ_B;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            burst_q      <= burst_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign release_now = q_ack && (!burst_q || (cnt_q == last_beat));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        burst_d      = burst_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                // Stray acks here are ignored; the counter only moves under a grant.
                if (pick_valid) begin
                    state_d      = (pick == REQ_A) ? GRANT_A : GRANT_B;
                    last_grant_d = pick;
                    burst_d      = (pick == REQ_A) ? a_burst : b_burst;
                    cnt_d        = '0;
                end
            end
            GRANT_A, GRANT_B: begin
                if (q_ack) begin
                    if (release_now) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_w'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sel_cmd  = '0;
        q_access = 1'b0;
        a_ack    = 1'b0;
        b_ack    = 1'b0;
        case (state_q)
            GRANT_A: begin
                sel_cmd  = a_cmd;
                q_access = a_access;
                a_ack    = q_ack;
            end
            GRANT_B: begin
                sel_cmd  = b_cmd;
                q_access = b_access;
                b_ack    = q_ack;
            end
            default: begin
                sel_cmd  = '0;
                q_access = 1'b0;
            end
        endcase
    end

    assign q_addr     = sel_cmd.addr;
    assign q_data_out = sel_cmd.data;
    assign q_wr_en    = sel_cmd.wr_en;
    assign q_bytesel  = sel_cmd.bytesel;

endmodule

// File: tb/tb_burst_arbiter.sv
// Self-checking bench for burst_arbiter: vector table, burst corner sequences, random traffic vs. a model.
module tb_burst_arbiter;

    localparam int BL = 8;
`ifdef BURST_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam logic [18:0] A_ADR = 19'h01234;
    localparam logic [18:0] B_ADR = 19'h05678;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] a_addr, b_addr, q_addr;
    logic [15:0] a_data_out, b_data_out, q_data_out;
    logic [15:0] a_data_in, b_data_in, q_data_in;
    logic        a_access, b_access, q_access;
    logic        a_ack, b_ack, q_ack;
    logic        a_wr_en, b_wr_en, q_wr_en;
    logic [1:0]  a_bytesel, b_bytesel, q_bytesel;
    logic        a_burst, b_burst;

    burst_arbiter #(.burst_len(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_addr     (a_addr),
        .a_data_out (a_data_out),
        .a_data_in  (a_data_in),
        .a_access   (a_access),
        .a_ack      (a_ack),
        .a_wr_en    (a_wr_en),
        .a_bytesel  (a_bytesel),
        .a_burst    (a_burst),
        .b_addr     (b_addr),
        .b_data_out (b_data_out),
        .b_data_in  (b_data_in),
        .b_access   (b_access),
        .b_ack      (b_ack),
        .b_wr_en    (b_wr_en),
        .b_bytesel  (b_bytesel),
        .b_burst    (b_burst),
        .q_addr     (q_addr),
        .q_data_out (q_data_out),
        .q_data_in  (q_data_in),
        .q_access   (q_access),
        .q_ack      (q_ack),
        .q_wr_en    (q_wr_en),
        .q_bytesel  (q_bytesel)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the port, how many acks remain, who won last.
    int m_owner = 0;   // 0 none, 1 A, 2 B
    int m_rem   = 0;
    int m_last  = 2;
    int n_txn   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int own;
        logic [31:0] e_acc, e_addr, e_dat, e_wr, e_bs;
        own    = reset ? 0 : m_owner;
        e_acc  = (own == 1) ? 32'(a_access)   : (own == 2) ? 32'(b_access)   : 32'd0;
        e_addr = (own == 1) ? 32'(a_addr)     : (own == 2) ? 32'(b_addr)     : 32'd0;
        e_dat  = (own == 1) ? 32'(a_data_out) : (own == 2) ? 32'(b_data_out) : 32'd0;
        e_wr   = (own == 1) ? 32'(a_wr_en)    : (own == 2) ? 32'(b_wr_en)    : 32'd0;
        e_bs   = (own == 1) ? 32'(a_bytesel)  : (own == 2) ? 32'(b_bytesel)  : 32'd0;
        chk("m_q_access", 32'(q_access), e_acc);
        chk("m_q_addr", 32'(q_addr), e_addr);
        chk("m_q_data_out", 32'(q_data_out), e_dat);
        chk("m_q_wr_en", 32'(q_wr_en), e_wr);
        chk("m_q_bytesel", 32'(q_bytesel), e_bs);
        chk("m_a_ack", 32'(a_ack), 32'((own == 1) && q_ack));
        chk("m_b_ack", 32'(b_ack), 32'((own == 2) && q_ack));
        chk("m_a_data_in", 32'(a_data_in), 32'(q_data_in));
        chk("m_b_data_in", 32'(b_data_in), 32'(q_data_in));
    endtask

    task automatic model_update();
        int w;
        if (reset) begin
            m_owner = 0;
            m_rem   = 0;
            m_last  = 2;
        end else if (m_owner == 0) begin
            if (a_access || b_access) begin
                if (a_access && b_access)
                    w = FIXED ? 1 : ((m_last == 1) ? 2 : 1);
                else
                    w = a_access ? 1 : 2;
                m_owner = w;
                m_last  = w;
                m_rem   = ((w == 1) ? a_burst : b_burst) ? BL : 1;
            end
        end else if (q_ack) begin
            m_rem--;
            if (m_rem == 0) begin
                n_txn++;
                $display("txn %0d: requester %s released", n_txn, (m_owner == 1) ? "A" : "B");
                m_owner = 0;
            end
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic sample(output logic aa, output logic bb);
        @(negedge clk);
        model_check();
        aa = a_ack;
        bb = b_ack;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        logic aa, bb;
        sample(aa, bb);
    endtask

    // Run one locked burst for A or B with an ack every granted cycle.
    task automatic burst_run(input bit use_b, input string tag);
        int cyc, n, other;
        logic aa, bb;
        cyc = 0; n = 0; other = 0;
        a_access = !use_b; a_burst = !use_b;
        b_access = use_b;  b_burst = use_b;
        while (n < BL && cyc < 40) begin
            if (cyc > 0) begin
                a_burst = 1'b0;
                b_burst = 1'b0;
            end
            #1 q_ack = q_access;
            sample(aa, bb);
            cyc++;
            if (use_b ? bb : aa) n++;
            if (use_b ? aa : bb) other++;
        end
        chk({tag, "_acks"}, 32'(n), 32'(BL));
        chk({tag, "_cycles"}, 32'(cyc), 32'(BL + 1));
        chk({tag, "_other_ack"}, 32'(other), 32'd0);
        a_access = 1'b0;
        b_access = 1'b0;
        #1 q_ack = 1'b1;
        sample(aa, bb);
        chk({tag, "_tail_a_ack"}, 32'(aa), 32'd0);
        chk({tag, "_tail_b_ack"}, 32'(bb), 32'd0);
        q_ack = 1'b0;
        $display("%s: %0d acks in %0d cycles", tag, n, cyc);
    endtask

    typedef struct {
        logic        rst;
        logic        a_acc;
        logic        b_acc;
        logic        qack;
        logic        e_aack;
        logic        e_back;
        logic        e_qacc;
        logic [18:0] e_qaddr;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic aa, input logic ba, input logic qa,
                                input logic ea, input logic eb, input logic eq, input logic [18:0] ead);
        vec_t v;
        v.rst = rst; v.a_acc = aa; v.b_acc = ba; v.qack = qa;
        v.e_aack = ea; v.e_back = eb; v.e_qacc = eq; v.e_qaddr = ead;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[$];
        logic aa, bb, prev_aack;
        int na, nb, a_at_b, n5;

        reset = 1'b1;
        a_addr = A_ADR; b_addr = B_ADR;
        a_data_out = 16'h1111; b_data_out = 16'h2222;
        a_wr_en = 1'b1; b_wr_en = 1'b0;
        a_bytesel = 2'b01; b_bytesel = 2'b10;
        a_burst = 1'b0; b_burst = 1'b0;
        a_access = 1'b1; b_access = 1'b1;
        q_ack = 1'b1; q_data_in = 16'hBEEF;

        // Reset state: requests and backend acks present but everything held low.
        #1;
        @(negedge clk);
        chk("rst_q_access", 32'(q_access), 32'd0);
        chk("rst_q_addr", 32'(q_addr), 32'd0);
        chk("rst_a_ack", 32'(a_ack), 32'd0);
        chk("rst_b_ack", 32'(b_ack), 32'd0);
        model_check();
        @(posedge clk);
        model_update();
        #1;
        reset = 1'b0;
        a_access = 1'b0; b_access = 1'b0; q_ack = 1'b0;

        // Single read for A, stray ack, then tie-breaking from a fresh reset.
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 19'h0));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 1, A_ADR));
        tv.push_back(mk(0, 1, 0, 1, 1, 0, 1, A_ADR));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 19'h0));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 19'h0));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 19'h0));
        tv.push_back(mk(0, 1, 1, 0, 0, 0, 0, 19'h0));
        tv.push_back(mk(0, 1, 1, 1, 1, 0, 1, A_ADR));
        tv.push_back(mk(0, 1, 1, 0, 0, 0, 0, 19'h0));
        tv.push_back(mk(0, 1, 1, 1, FIXED, !FIXED, 1, FIXED ? A_ADR : B_ADR));
        tv.push_back(mk(0, 1, 1, 0, 0, 0, 0, 19'h0));
        tv.push_back(mk(0, 1, 1, 1, 1, 0, 1, A_ADR));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 19'h0));

        for (int i = 0; i < tv.size(); i++) begin
            reset = tv[i].rst; a_access = tv[i].a_acc; b_access = tv[i].b_acc; q_ack = tv[i].qack;
            @(negedge clk);
            chk($sformatf("vec%0d_a_ack", i), 32'(a_ack), 32'(tv[i].e_aack));
            chk($sformatf("vec%0d_b_ack", i), 32'(b_ack), 32'(tv[i].e_back));
            chk($sformatf("vec%0d_q_access", i), 32'(q_access), 32'(tv[i].e_qacc));
            chk($sformatf("vec%0d_q_addr", i), 32'(q_addr), 32'(tv[i].e_qaddr));
            chk($sformatf("vec%0d_a_data_in", i), 32'(a_data_in), 32'h0000BEEF);
            $display("vec %0d: a_ack=%0b b_ack=%0b q_access=%0b q_addr=%05h", i, a_ack, b_ack, q_access, q_addr);
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end
        reset = 1'b0; q_ack = 1'b0;

        // A line fill with gaps after each ack; B starts requesting at beat 3.
        na = 0; nb = 0; a_at_b = -1; prev_aack = 1'b0;
        a_burst = 1'b1;
        for (int k = 0; k < 100 && nb == 0; k++) begin
            if (k > 0) a_burst = 1'b0;
            a_access = (na < BL) && !prev_aack;
            b_access = (na >= 3);
            b_burst = 1'b0;
            #1 q_ack = q_access && k[0];
            sample(aa, bb);
            if (aa) na++;
            if (bb) begin
                nb++;
                a_at_b = na;
            end
            prev_aack = aa;
        end
        chk("fill_a_acks", 32'(na), 32'(BL));
        chk("fill_b_granted", 32'(nb), 32'd1);
        chk("fill_a_acks_before_b", 32'(a_at_b), 32'(BL));
        $display("fill: A got %0d acks, B first acked after %0d A acks", na, a_at_b);
        a_access = 1'b0; b_access = 1'b0; q_ack = 1'b0;
        cycle();

        // B burst interrupted by reset after beat 5, then re-requested from scratch.
        n5 = 0;
        b_access = 1'b1; b_burst = 1'b1;
        for (int k = 0; k < 30 && n5 < 5; k++) begin
            if (k > 0) b_burst = 1'b0;
            #1 q_ack = q_access;
            sample(aa, bb);
            if (bb) n5++;
        end
        chk("rst_mid_beats", 32'(n5), 32'd5);
        reset = 1'b1; q_ack = 1'b1;
        #1;
        @(negedge clk);
        chk("rst_mid_q_access", 32'(q_access), 32'd0);
        chk("rst_mid_b_ack", 32'(b_ack), 32'd0);
        model_check();
        @(posedge clk);
        model_update();
        #1;
        reset = 1'b0; q_ack = 1'b0;
        $display("reset mid-burst after %0d beats", n5);
        burst_run(1'b1, "b_after_reset");

        // Stray ack in IDLE, then a full A burst must still count every beat.
        q_ack = 1'b1;
        sample(aa, bb);
        chk("stray_a_ack", 32'(aa), 32'd0);
        chk("stray_b_ack", 32'(bb), 32'd0);
        q_ack = 1'b0;
        burst_run(1'b0, "a_after_stray");

        // Random traffic checked cycle by cycle against the model.
        for (int k = 0; k < 2500; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            a_access = a_access ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            b_access = b_access ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            a_burst = 1'($urandom_range(0, 1));
            b_burst = 1'($urandom_range(0, 1));
            a_addr = 19'($urandom); b_addr = 19'($urandom);
            a_data_out = 16'($urandom); b_data_out = 16'($urandom);
            a_wr_en = 1'($urandom); b_wr_en = 1'($urandom);
            a_bytesel = 2'($urandom); b_bytesel = 2'($urandom);
            q_data_in = 16'($urandom);
            #1 q_ack = 1'($urandom_range(0, 1));
            cycle();
        end
        reset = 1'b0; a_access = 1'b0; b_access = 1'b0; q_ack = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
